cla_word_sequencer: RTL
=======================

# cla_word_sequencer

Multi-precision add sequencer for the 16-bit carry lookahead adder datapath. It accepts two WORDS×16-bit operands over a valid/ready handshake and feeds them through one shared combinational 16-bit CLA, one 16-bit limb per cycle, LSB limb first. Each limb's carry-out is chained into the next limb's carry-in, and the full-width sum, carry-out and signed overflow are returned over a second valid/ready handshake. It sits between the operand-issuing logic and the CLA instance and owns all of the adder's input ports.

## Interface
- WORDS, 4, number of 16-bit limbs per operand; legal range 1–16; operand width W = 16*WORDS
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  operand request valid
- start_ready  out  1  sequencer can accept an operand request
- a_in  in  W  operand A
- b_in  in  W  operand B
- cin  in  1  carry into limb 0
- sub  in  1  subtract request; present only when CLA_SEQ_SUB_EN is defined
- add_x  out  16  CLA x input (current A limb)
- add_y  out  16  CLA y input (current effective B limb)
- add_c  out  1  CLA carry-in
- add_result  in  17  CLA result; [15:0] sum, [16] carry-out; combinational from add_x/add_y/add_c
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_sum  out  W  full-width sum
- res_cout  out  1  carry out of the top limb
- res_ovf  out  1  two's-complement signed overflow of the W-bit operation

## Operation
- FSM states: IDLE, RUN, DONE. rst forces IDLE from any state.
- **IDLE:**
  - start_ready=1.
  - On start_valid: capture a_in, the effective B (b_in, or ~b_in when subtracting) and the initial carry; clear the limb index; go to RUN.
- **RUN:**
  - add_x = A limb[idx], add_y = B limb[idx], add_c = carry register.
  - Each cycle, write add_result[15:0] into res_sum limb[idx] and add_result[16] into the carry register, then increment idx.
  - When idx = WORDS-1 is written, go to DONE.
- **DONE:**
  - res_valid=1; res_sum, res_cout and res_ovf are held stable.
  - On res_ready, go to IDLE.
- **Outputs:**
  - res_cout = final carry register.
  - res_ovf = (A[W-1] == Beff[W-1]) && (res_sum[W-1] != A[W-1]).
- **Idle CLA drive:** in IDLE and DONE, add_x=0, add_y=0, add_c=0.
- **Busy behaviour:**
  - start_ready=0 in RUN and DONE.
  - start_valid asserted then is ignored and no operands are captured.
  - No queueing.
- **Reset values:** start_ready=1 (IDLE after reset), res_valid=0, res_sum=0, res_cout=0, res_ovf=0, add_x=0, add_y=0, add_c=0. Internal idx and carry registers are also cleared.
- **Reset mid-operation:** the operation is abandoned with no partial result emitted. The next cycle is IDLE with reset values.
- **Stale inputs:** operands are registered at acceptance, so changes on a_in/b_in/cin after the handshake have no effect.
- **Carry wrap:** the carry-out of the top limb goes only to res_cout. The sum wraps modulo 2^W.

## Timing
- Acceptance edge E0: start_valid && start_ready sampled high.
- Limb k is written at edge E(k+1), for k = 0..WORDS-1.
- res_valid rises after edge E(WORDS), so latency from accept to res_valid is WORDS cycles (4 at the default).
- Result handshake completes on the edge where res_valid && res_ready.
  - res_valid falls after that edge.
  - start_ready rises after that same edge.
- Earliest next accept is the edge after the result handshake, so steady-state throughput is one operation per WORDS+2 cycles with res_ready held high.
- Combinational paths: add_result to the res_sum registers only. No input-to-output combinational path exists on the handshake signals.

## Configuration
- **CLA_SEQ_SUB_EN defined:**
  - The sub port exists.
  - sub=1 at acceptance captures Beff = ~b_in with initial carry 1 (cin ignored), giving A−B. res_cout=1 means no borrow.
  - sub=0 behaves as the plain add.
- **CLA_SEQ_SUB_EN undefined:**
  - No sub port.
  - Beff = b_in and initial carry = cin always.

## Test plan
All scenarios use WORDS=4 and a behavioural 17-bit CLA model.
- **Basic add:** a=0x000F, b=0x0001, cin=0 → res_sum=0x0000_0000_0000_0010, cout=0, ovf=0. res_valid must appear exactly 4 cycles after accept.
- **Full ripple:** a=0xFFFF_FFFF_FFFF_FFFF, b=0x1 → res_sum=0, cout=1, ovf=0. Observed add_c sequence over RUN must be 0,1,1,1.
- **Signed overflow:** a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 → res_sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- **Backpressure:**
  - Stimulus: res_ready held low for 10 cycles in DONE while start_valid pulses with new operands.
  - Required: res_valid stays 1, res_sum stable, start_ready 0, and the new operands are not captured.
  - Then raise res_ready: start_ready goes to 1 on the next cycle.
- **Reset mid-RUN:**
  - Stimulus: assert rst for one cycle while idx=2.
  - Required: the next cycle shows start_ready=1, res_valid=0, all outputs at reset values.
  - Required: a following op 66+400 yields res_sum=466.
- **Subtract (CLA_SEQ_SUB_EN):** a=5, b=7, sub=1 → res_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.

Source files
------------

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer
// Multi-precision add sequencer in front of a shared combinational 16-bit CLA.
// Two WORDS x 16-bit operands are accepted over a valid/ready handshake, then
// pushed through the CLA one limb per cycle (LSB limb first), with each limb's
// carry-out chained into the next limb's carry-in. The full-width sum, carry-out
// and signed overflow are returned over a second valid/ready handshake.
//
// Optional feature macro: CLA_SEQ_SUB_EN adds the 'sub' port. With sub=1 at
// acceptance, B is inverted and the initial carry forced to 1, giving A-B.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_valid/start_ready   operand request handshake
//   a_in, b_in, cin           operands and carry into limb 0
//   sub                       subtract request (CLA_SEQ_SUB_EN only)
//   add_x, add_y, add_c       drive to the CLA (zero when not in RUN)
//   add_result                CLA result {carry-out, sum[15:0]}
//   res_valid/res_ready       result handshake
//   res_sum, res_cout, res_ovf  full-width sum, top carry, signed overflow
module cla_word_sequencer #(
  parameter  int WORDS = 4,
  localparam int W     = 16 * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic [15:0]  add_x,
  output logic [15:0]  add_y,
  output logic         add_c,
  input  logic [16:0]  add_result,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_ovf
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic [IDX_W-1:0] idx_q;

  // Effective B operand and initial carry as captured at acceptance
  logic [W-1:0]     b_eff_d;
  logic             carry_d;

  // Signed overflow: operands share a sign and the result sign differs from it
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  always_comb begin
`ifdef CLA_SEQ_SUB_EN
    b_eff_d = sub ? ~b_in : b_in;
    carry_d = sub ? 1'b1 : cin;
`else
    b_eff_d = b_in;
    carry_d = cin;
`endif
  end

  // CLA drive: current limb only while running, otherwise held at zero
  always_comb begin
    add_x = '0;
    add_y = '0;
    add_c = 1'b0;
    if (state_q == RUN) begin
      add_x = a_q[int'(idx_q) * 16 +: 16];
      add_y = b_q[int'(idx_q) * 16 +: 16];
      add_c = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a_in;
            b_q     <= b_eff_d;
            carry_q <= carry_d;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(idx_q) * 16 +: 16] <= add_result[15:0];
          carry_q <= add_result[16];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            // Top limb: its sum bit 15 is the result sign bit
            ovf_q   <= signed_ovf(a_q[W-1], b_q[W-1], add_result[15]);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign res_sum     = sum_q;
  assign res_cout    = carry_q;
  assign res_ovf     = ovf_q;

endmodule
